hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

- Parametrised data-hazard unit for the pipelined CPU. It sits beside the ID stage.
- It keeps a shift-register scoreboard of in-flight register writes across `NSTAGE` post-ID stages, with a per-entry result-latency countdown.
- Each cycle it produces a forwarding select for each of `NSRC` source operands, plus a load-use/multi-cycle stall.
- It generalises the fixed two-stage, two-source, load-only hazard logic: configurable depth, source count and per-instruction result latency, a downstream hold, and a stall counter.

## Interface

Parameters:
- `AW`, 5: register address width; address 0 is hardwired zero and never hazards.
- `NSRC`, 2: source operands per instruction.
- `NSTAGE`, 2: post-ID stages that can forward (stage 1 = ID/EX … stage `NSTAGE` = last before writeback).
- `SELW`, `$clog2(NSTAGE+1)`: forwarding select width (derived, do not override).
- `CNTW`, 32: stall counter width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: instruction present in ID.
- `id_src_addr` in `NSRC*AW`: source register addresses, source i at `[i*AW +: AW]`.
- `id_src_used` in `NSRC`: source i is actually read.
- `id_reg_write` in 1: instruction writes a register.
- `id_dst_addr` in `AW`: destination register.
- `id_lat` in `SELW`: result latency in stages (1 = ALU, 2 = load, …). Values above `NSTAGE` are clamped to `NSTAGE`; 0 is treated as `id_reg_write` = 0.
- `ex_hold` in 1: downstream freeze (e.g. memory wait).
- `fwd_sel` out `NSRC*SELW`: per source: 0 = register file, k = forward from stage k.
- `stall` out 1: hold PC/IF/ID and insert a bubble into stage 1.
- `stall_cycles` out `CNTW`: saturating count of cycles with `stall` = 1.

## Operation

**State**
- Entries `e[1..NSTAGE]`, each holding `{valid, dst[AW], rem[SELW]}`.
- `rem` = stages remaining until the result exists. The entry is forwardable when `rem` = 0.

**Source resolution** (combinational, per source i)
- A match is an entry with `valid`, `dst` ≠ 0, `dst == src_i`, `id_src_used[i]` = 1 and `id_valid` = 1.
- The lowest-k (youngest) match wins.
- If that match has `rem` = 0: `fwd_sel_i` = k.
- If that match has `rem` > 0: `stall` is raised. `fwd_sel_i` is don't-care, but is driven 0.
- If there is no match: `fwd_sel_i` = 0.
- `stall` = (any source stalls) OR `ex_hold`.

**Update at `posedge clk`**
- If `ex_hold`: no entry changes.
- Otherwise, for k = `NSTAGE` down to 2: `e[k]` ← `e[k-1]`, with `rem` decremented, saturating at 0. `e[NSTAGE]` retires and is written to the register file.
- `e[1]` is loaded as follows:
  - Issue (`id_valid` and not `stall`) with a write: `{id_reg_write && id_lat != 0, id_dst_addr, clamp(id_lat) - 1}`.
  - Issue without a write: `valid` = 0.
  - `stall` = 1 (bubble): `valid` = 0.
- `stall_cycles` increments when `stall` = 1 and saturates at all-ones.

**Boundary rules**
- The register file is write-before-read. An entry that has retired is no longer matched, so `fwd_sel` = 0 is correct.
- A destination of 0 never matches, even with `id_reg_write` = 1.
- A clamped latency of `NSTAGE` is resolved at stage `NSTAGE` at the latest. No deadlock is possible, because bubbles keep the entries shifting.
- `ex_hold` with a source stall: both hold, and the counter counts once per cycle.
- Reset mid-operation clears every entry asynchronously. In-flight hazards are forgotten, which is correct because the pipeline is reset too.

## Timing

- `fwd_sel` and `stall` are combinational from the current entries and the ID inputs, valid in the same cycle.
- Scoreboard and counter update on `posedge clk`.
- The minimum load-use penalty with defaults is 1 stall cycle. An instruction with latency L followed immediately by a dependant costs L−1 stall cycles.
- Reset values:
  - All entries: `valid` = 0, `dst` = 0, `rem` = 0.
  - `stall_cycles` = 0.
  - With `ex_hold` = 0: `stall` = 0 and `fwd_sel` = 0 for any ID inputs.

## Structure

- Shared CPU package holds `AW`, the `fwd_sel` encoding constants (`FWD_RF` = 0; stage k = k), and the latency class constants (`LAT_ALU` = 1, `LAT_LOAD` = 2).
- One natural sub-module, `hazard_src_match`: resolves one source against all entries (youngest-first priority) and returns `{stall_i, sel_i}`. It is instantiated `NSRC` times by a generate loop.

## Test plan

1. Defaults. Issue ALU `add r3` (lat 1), then `sub` reading r3 in `rs` → `fwd_sel` = {src1: 0, src0: 1}, `stall` = 0. One cycle later, a reader of r3 gets `sel` = 2. Two cycles later it gets 0.
2. Load `lw r5` (lat 2), next instruction reads r5 in `rt` → `stall` = 1 for exactly 1 cycle. Then `fwd_sel` for `rt` = 2, and `stall_cycles` = 1.
3. Both stages match the same register: `add r4` in stage 2 and `add r4` in stage 1, reader of r4 → `sel` = 1 (youngest wins). Any write to r0, or a read of r0 with `id_src_used` = 0 on a matching source → `sel` = 0, no stall.
4. `NSTAGE` = 4, `NSRC` = 3, `id_lat` = 6 (clamped to 4), dependant issued next → 3 stall cycles, then `sel` = 4. A third source matching an older lat-1 entry forwards concurrently.
5. `ex_hold` = 1 for 3 cycles while the load sits in stage 1 → entries frozen, `stall` = 1 throughout. On release, the prior resolution resumes unchanged. `stall_cycles` increments 4 total.
6. Assert `rst_n` low mid-stall, asynchronously, between clock edges → `stall` falls immediately (with `ex_hold` = 0), all `fwd_sel` = 0, `stall_cycles` = 0. A preloaded counter near all-ones saturates and does not wrap.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared CPU constants for the data-hazard scoreboard: register address width,
// forwarding select encoding and the result-latency classes.
package hazard_scoreboard_pkg;

    localparam int AW       = 5;

    // A forwarding select of k means "take the result from post-ID stage k".
    localparam int FWD_RF   = 0;

    localparam int LAT_ALU  = 1;
    localparam int LAT_LOAD = 2;

endpackage

// File: rtl/hazard_scoreboard_src_match.sv
// Resolves one ID source operand against every in-flight scoreboard entry.
// The youngest (lowest stage) matching entry decides between forward and stall.
module hazard_src_match #(
    parameter int AW     = hazard_scoreboard_pkg::AW,
    parameter int NSTAGE = 2,
    parameter int SELW   = $clog2(NSTAGE + 1)
) (
    input  logic                   i_id_valid,
    input  logic                   i_src_used,
    input  logic [AW-1:0]          i_src_addr,
    input  logic [NSTAGE-1:0]      i_ent_valid,
    input  logic [NSTAGE*AW-1:0]   i_ent_dst,
    input  logic [NSTAGE*SELW-1:0] i_ent_rem,
    output logic                   o_stall,
    output logic [SELW-1:0]        o_sel
);
    import hazard_scoreboard_pkg::*;

    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        o_stall = 1'b0;
        o_sel   = SELW'(FWD_RF);
        for (int k = NSTAGE; k >= 1; k--) begin
            if (i_id_valid && i_src_used && i_ent_valid[k-1] &&
                (i_ent_dst[(k-1)*AW +: AW] != '0) &&
                (i_ent_dst[(k-1)*AW +: AW] == i_src_addr)) begin
                if (i_ent_rem[(k-1)*SELW +: SELW] == '0) begin
                    o_stall = 1'b0;
                    o_sel   = SELW'(k);
                end else begin
                    o_stall = 1'b1;
                    o_sel   = SELW'(FWD_RF);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Data-hazard unit beside ID: shift-register scoreboard of in-flight writes with
// per-entry latency countdown, producing forwarding selects, stall and a stall counter.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int AW     = hazard_scoreboard_pkg::AW,
    parameter int NSRC   = 2,
    parameter int NSTAGE = 2,
    parameter int SELW   = $clog2(NSTAGE + 1),
    parameter int CNTW   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [NSRC*AW-1:0]     id_src_addr,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic                   id_reg_write,
    input  logic [AW-1:0]          id_dst_addr,
    input  logic [SELW-1:0]        id_lat,
    input  logic                   ex_hold,
    output logic [NSRC*SELW-1:0]   fwd_sel,
    output logic                   stall,
    output logic [CNTW-1:0]        stall_cycles
);

    // Stage k of the scoreboard lives at index k-1 of each flattened vector.
    logic [NSTAGE-1:0]      r_valid;
    logic [NSTAGE*AW-1:0]   r_dst;
    logic [NSTAGE*SELW-1:0] r_rem;
    logic [CNTW-1:0]        r_stallCnt;

    logic [NSRC-1:0]        w_srcStall;
    logic [SELW-1:0]        w_latClamp;
    logic                   w_issueWrite;
    logic [NSTAGE*SELW-1:0] w_remDec;

    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        hazard_src_match #(
            .AW     (AW),
            .NSTAGE (NSTAGE),
            .SELW   (SELW)
        ) u_match (
            .i_id_valid  (id_valid),
            .i_src_used  (id_src_used[gi]),
            .i_src_addr  (id_src_addr[gi*AW +: AW]),
            .i_ent_valid (r_valid),
            .i_ent_dst   (r_dst),
            .i_ent_rem   (r_rem),
            .o_stall     (w_srcStall[gi]),
            .o_sel       (fwd_sel[gi*SELW +: SELW])
        );
    end

    assign stall        = (|w_srcStall) || ex_hold;
    assign stall_cycles = r_stallCnt;

    // A latency of 0 means the instruction produces nothing worth tracking.
    assign w_latClamp   = (id_lat > SELW'(NSTAGE)) ? SELW'(NSTAGE) : id_lat;
    assign w_issueWrite = id_valid && !stall && id_reg_write && (id_lat != '0);

    always_comb begin
        w_remDec = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            w_remDec[k*SELW +: SELW] = (r_rem[k*SELW +: SELW] == '0) ?
                                       '0 : r_rem[k*SELW +: SELW] - SELW'(1);
        end
    end

    // Entries move one stage per unfrozen cycle; stage 1 takes the issuing write or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dst   <= '0;
            r_rem   <= '0;
        end else if (!ex_hold) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                r_valid[k-1]                <= r_valid[k-2];
                r_dst[(k-1)*AW +: AW]       <= r_dst[(k-2)*AW +: AW];
                r_rem[(k-1)*SELW +: SELW]   <= w_remDec[(k-2)*SELW +: SELW];
            end
            r_valid[0]        <= w_issueWrite;
            r_dst[0 +: AW]    <= w_issueWrite ? id_dst_addr : '0;
            r_rem[0 +: SELW]  <= w_issueWrite ? (w_latClamp - SELW'(1)) : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
        end else if (stall && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance and a deep instance (NSTAGE=4,
// NSRC=3, narrow counter) driven from one record table through an expected-result queue.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              aValid, aWr, aHold, aStall;
    logic [2*AW-1:0]   aSrcAddr;
    logic [1:0]        aUsed, aLat;
    logic [AW-1:0]     aDst;
    logic [3:0]        aFwd;
    logic [31:0]       aCnt;

    logic              bValid, bWr, bHold, bStall;
    logic [3*AW-1:0]   bSrcAddr;
    logic [2:0]        bUsed, bLat;
    logic [AW-1:0]     bDst;
    logic [8:0]        bFwd;
    logic [1:0]        bCnt;

    hazard_scoreboard #(
        .AW(AW), .NSRC(2), .NSTAGE(2), .CNTW(32)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .id_valid(aValid), .id_src_addr(aSrcAddr),
        .id_src_used(aUsed), .id_reg_write(aWr), .id_dst_addr(aDst), .id_lat(aLat),
        .ex_hold(aHold), .fwd_sel(aFwd), .stall(aStall), .stall_cycles(aCnt)
    );

    hazard_scoreboard #(
        .AW(AW), .NSRC(3), .NSTAGE(4), .CNTW(2)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .id_valid(bValid), .id_src_addr(bSrcAddr),
        .id_src_used(bUsed), .id_reg_write(bWr), .id_dst_addr(bDst), .id_lat(bLat),
        .ex_hold(bHold), .fwd_sel(bFwd), .stall(bStall), .stall_cycles(bCnt)
    );

    typedef struct {
        string              name;
        bit                 dut;
        bit                 valid;
        logic [2:0][AW-1:0] src;
        logic [2:0]         used;
        bit                 wr;
        logic [AW-1:0]      dst;
        logic [2:0]         lat;
        bit                 hold;
        logic [2:0][2:0]    expSel;
        bit                 expStall;
        int                 expCnt;
    } vec_t;

    vec_t vecs[$];
    vec_t expQ[$];
    int   testCount = 0;
    int   failCount = 0;

    function automatic vec_t mkVec(input string name, input int dut, input int valid,
                                   input int s2, input int s1, input int s0, input int used,
                                   input int wr, input int dst, input int lat, input int hold,
                                   input int e2, input int e1, input int e0,
                                   input int expStall, input int expCnt);
        vec_t v;
        v.name      = name;
        v.dut       = 1'(dut);
        v.valid     = 1'(valid);
        v.src[2]    = AW'(s2);
        v.src[1]    = AW'(s1);
        v.src[0]    = AW'(s0);
        v.used      = 3'(used);
        v.wr        = 1'(wr);
        v.dst       = AW'(dst);
        v.lat       = 3'(lat);
        v.hold      = 1'(hold);
        v.expSel[2] = 3'(e2);
        v.expSel[1] = 3'(e1);
        v.expSel[0] = 3'(e0);
        v.expStall  = 1'(expStall);
        v.expCnt    = expCnt;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        aValid = 1'b0; aSrcAddr = '0; aUsed = '0; aWr = 1'b0; aDst = '0; aLat = '0; aHold = 1'b0;
        bValid = 1'b0; bSrcAddr = '0; bUsed = '0; bWr = 1'b0; bDst = '0; bLat = '0; bHold = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idleInputs();
        if (v.dut == 1'b0) begin
            aValid   = v.valid;
            aSrcAddr = {v.src[1], v.src[0]};
            aUsed    = v.used[1:0];
            aWr      = v.wr;
            aDst     = v.dst;
            aLat     = v.lat[1:0];
            aHold    = v.hold;
        end else begin
            bValid   = v.valid;
            bSrcAddr = {v.src[2], v.src[1], v.src[0]};
            bUsed    = v.used;
            bWr      = v.wr;
            bDst     = v.dst;
            bLat     = v.lat;
            bHold    = v.hold;
        end
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        if (expQ.size() == 0) begin
            testCount++;
            failCount++;
            $display("[TB] FAIL scoreboardEmpty: got 0 entries, expected at least 1");
        end else begin
            e = expQ.pop_front();
            if (e.dut == 1'b0) begin
                checkValue({e.name, ".fwd_sel"}, 32'(aFwd),
                           32'({e.expSel[1][1:0], e.expSel[0][1:0]}));
                checkValue({e.name, ".stall"}, 32'(aStall), 32'(e.expStall));
                checkValue({e.name, ".stall_cycles"}, aCnt, 32'(e.expCnt));
            end else begin
                checkValue({e.name, ".fwd_sel"}, 32'(bFwd),
                           32'({e.expSel[2], e.expSel[1], e.expSel[0]}));
                checkValue({e.name, ".stall"}, 32'(bStall), 32'(e.expStall));
                checkValue({e.name, ".stall_cycles"}, 32'(bCnt), 32'(e.expCnt));
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish within 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Fields: name, dut, valid, src2, src1, src0, used, wr, dst, lat, hold, sel2, sel1, sel0, stall, cnt
        vecs.push_back(mkVec("aluAdd",       0,1, 0,2,1,  3, 1,3,1,  0, 0,0,0, 0,0));
        vecs.push_back(mkVec("fwdStage1",    0,1, 0,4,3,  3, 1,6,1,  0, 0,0,1, 0,0));
        vecs.push_back(mkVec("fwdStage2",    0,1, 0,0,3,  1, 0,0,0,  0, 0,0,2, 0,0));
        vecs.push_back(mkVec("retired",      0,1, 0,7,3,  3, 0,0,0,  0, 0,0,0, 0,0));
        vecs.push_back(mkVec("loadIssue",    0,1, 0,2,1,  3, 1,5,2,  0, 0,0,0, 0,0));
        vecs.push_back(mkVec("loadUseStall", 0,1, 0,5,1,  3, 1,8,1,  0, 0,0,0, 1,0));
        vecs.push_back(mkVec("loadUseFwd",   0,1, 0,5,1,  3, 1,8,1,  0, 0,2,0, 0,1));
        vecs.push_back(mkVec("addR4a",       0,1, 0,0,0,  0, 1,4,1,  0, 0,0,0, 0,1));
        vecs.push_back(mkVec("addR4b",       0,1, 0,0,8,  1, 1,4,1,  0, 0,0,2, 0,1));
        vecs.push_back(mkVec("youngestWins", 0,1, 0,4,4,  3, 1,0,2,  0, 0,1,1, 0,1));
        vecs.push_back(mkVec("readR0",       0,1, 0,0,0,  3, 0,0,0,  0, 0,0,0, 0,1));
        vecs.push_back(mkVec("loadR9",       0,1, 0,0,0,  0, 1,9,2,  0, 0,0,0, 0,1));
        vecs.push_back(mkVec("unusedSrc",    0,1, 0,9,9,  0, 0,0,0,  0, 0,0,0, 0,1));
        vecs.push_back(mkVec("idInvalid",    0,0, 0,9,9,  3, 0,0,0,  0, 0,0,0, 0,1));
        vecs.push_back(mkVec("loadR10",      0,1, 0,0,0,  0, 1,10,2, 0, 0,0,0, 0,1));
        vecs.push_back(mkVec("holdStall1",   0,1, 0,0,10, 1, 0,0,0,  1, 0,0,0, 1,1));
        vecs.push_back(mkVec("holdStall2",   0,1, 0,0,10, 1, 0,0,0,  1, 0,0,0, 1,2));
        vecs.push_back(mkVec("holdStall3",   0,1, 0,0,10, 1, 0,0,0,  1, 0,0,0, 1,3));
        vecs.push_back(mkVec("releaseStall", 0,1, 0,0,10, 1, 0,0,0,  0, 0,0,0, 1,4));
        vecs.push_back(mkVec("holdOnly",     0,0, 0,0,0,  0, 0,0,0,  1, 0,0,0, 1,5));
        vecs.push_back(mkVec("fwdAfterHold", 0,1, 0,10,0, 2, 0,0,0,  0, 0,2,0, 0,6));
        vecs.push_back(mkVec("latZero",      0,1, 0,0,0,  0, 1,12,0, 0, 0,0,0, 0,6));
        vecs.push_back(mkVec("latZeroRead",  0,1, 0,0,12, 1, 0,0,0,  0, 0,0,0, 0,6));
        vecs.push_back(mkVec("latClamp",     0,1, 0,0,0,  0, 1,13,3, 0, 0,0,0, 0,6));
        vecs.push_back(mkVec("clampStall",   0,1, 0,0,13, 1, 0,0,0,  0, 0,0,0, 1,6));
        vecs.push_back(mkVec("clampFwd",     0,1, 0,0,13, 1, 0,0,0,  0, 0,0,2, 0,7));
        vecs.push_back(mkVec("deepAlu",      1,1, 0,0,0,  0, 1,7,1,  0, 0,0,0, 0,0));
        vecs.push_back(mkVec("deepLoad",     1,1, 0,0,0,  0, 1,20,6, 0, 0,0,0, 0,0));
        vecs.push_back(mkVec("deepStall1",   1,1, 7,0,20, 5, 0,0,0,  0, 2,0,0, 1,0));
        vecs.push_back(mkVec("deepStall2",   1,1, 7,0,20, 5, 0,0,0,  0, 3,0,0, 1,1));
        vecs.push_back(mkVec("deepStall3",   1,1, 7,0,20, 5, 0,0,0,  0, 4,0,0, 1,2));
        vecs.push_back(mkVec("deepFwd",      1,1, 7,0,20, 5, 0,0,0,  0, 0,0,4, 0,3));
        vecs.push_back(mkVec("deepSat",      1,0, 0,0,0,  0, 0,0,0,  1, 0,0,0, 1,3));
        vecs.push_back(mkVec("deepSatHold",  1,0, 0,0,0,  0, 0,0,0,  0, 0,0,0, 0,3));

        // Reset state: matching-looking ID inputs must not produce hazards.
        idleInputs();
        rst_n = 1'b0;
        aValid = 1'b1; aSrcAddr = {AW'(2), AW'(1)}; aUsed = 2'b11;
        bValid = 1'b1; bSrcAddr = {AW'(3), AW'(2), AW'(1)}; bUsed = 3'b111;
        #2;
        checkValue("resetA.stall", 32'(aStall), 32'd0);
        checkValue("resetA.fwd_sel", 32'(aFwd), 32'd0);
        checkValue("resetA.stall_cycles", aCnt, 32'd0);
        checkValue("resetB.stall", 32'(bStall), 32'd0);
        checkValue("resetB.stall_cycles", 32'(bCnt), 32'd0);
        @(negedge clk);
        idleInputs();
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #2;
            checkOutput();
        end

        // Asynchronous reset landing in the middle of a load-use stall.
        @(negedge clk);
        applyStimulus(mkVec("rstLoad",     0,1, 0,0,0,  0, 1,11,2, 0, 0,0,0, 0,7));
        #2;
        checkOutput();
        @(negedge clk);
        applyStimulus(mkVec("rstPreStall", 0,1, 0,0,11, 1, 0,0,0,  0, 0,0,0, 1,7));
        #2;
        checkOutput();
        #1;
        rst_n = 1'b0;
        #1;
        checkValue("asyncReset.stall", 32'(aStall), 32'd0);
        checkValue("asyncReset.fwd_sel", 32'(aFwd), 32'd0);
        checkValue("asyncReset.stall_cycles", aCnt, 32'd0);
        checkValue("asyncResetB.stall_cycles", 32'(bCnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkValue("afterReset.stall", 32'(aStall), 32'd0);
        checkValue("afterReset.fwd_sel", 32'(aFwd), 32'd0);
        @(posedge clk);
        #1;
        checkValue("afterReset.stall_cycles", aCnt, 32'd0);

        idleInputs();
        checkValue("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
